imem_ctrl: RTL and testbench
============================

Name: imem_ctrl

Overview:
- Responder end of the processor's instruction-fetch interface.
- Accepts word-aligned fetch requests from the fetch stage and returns the 32-bit instruction a fixed LATENCY cycles later.
- Supports a cancel on taken branches and a side port for loading the program image.
- Sits between the fetch stage and the instruction storage; it is the memory model used for multi-cycle fetch experiments.

Parameters:
- MEM_WORDS, 1024, number of 32-bit instruction words stored (power of two).
- LATENCY, 2, cycles from request acceptance to response valid; legal range 1..15.
- NOP_INSN, 32'h00000013, word returned for out-of-range addresses.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- proc2Imem_req  in  1  fetch request valid
- proc2Imem_addr  in  32  byte address; bits [1:0] ignored
- proc2Imem_flush  in  1  cancel any outstanding fetch (taken branch)
- Imem2proc_ready  out  1  controller can accept a request this cycle
- Imem2proc_valid  out  1  response valid, single-cycle pulse
- Imem2proc_data  out  32  fetched instruction
- Imem2proc_err  out  1  response address was out of range (qualified by valid)
- load_en  in  1  program-load write enable
- load_addr  in  32  program-load byte address
- load_data  in  32  program-load word

Behaviour:
- Word index is addr[AW+1:2], where AW = clog2(MEM_WORDS). An address is out of range if addr[31:AW+2] != 0.
- FSM states: IDLE, WAIT, RESP.
  - Imem2proc_ready = (state==IDLE) && !rst.
  - Request is accepted when proc2Imem_req && Imem2proc_ready.
- On accept:
  - Memory word (or NOP_INSN) is captured into a data buffer; the err flag is captured alongside it.
  - If LATENCY==1: next state is RESP.
  - Otherwise: next state is WAIT, with down-counter = LATENCY-2.
- WAIT: the counter decrements each cycle; when the counter is 0, next state is RESP.
- RESP:
  - Imem2proc_valid=1; data/err are driven from the buffer.
  - Next state is IDLE. No accept in RESP, so back-to-back throughput is one fetch per LATENCY+1 cycles.
- Response timing: Imem2proc_valid asserts exactly LATENCY cycles after the accept edge.
- Imem2proc_data holds its last value when valid=0. Imem2proc_err=0 whenever valid=0.
- Flush:
  - proc2Imem_flush in WAIT or RESP: next state is IDLE, and valid is forced to 0 in that same cycle (combinational suppress in RESP). The buffer is discarded.
  - Flush in IDLE has no effect; a simultaneous req in IDLE is still accepted.
- Load port:
  - Writes the word at load_addr index on a clock edge when load_en=1 and the address is in range; out-of-range load writes are dropped.
  - Writes are legal in any state.
  - Read data is captured at accept, so a load to the word being fetched after accept does not change the pending response.
  - Load and accept to the same word in the same cycle: the fetch returns the old word.
- Reset:
  - state=IDLE, counter=0, data buffer=0, err=0, valid=0.
  - Memory contents are not reset.
  - Reset mid-WAIT/RESP drops the fetch silently, with no valid pulse.
- Counter width is 4 bits. LATENCY outside 1..15 is a fatal elaboration-time check.

Decomposition:
- sys_defs additions: `IMEM_NOP define; imem_state_t enum {IDLE, WAIT, RESP}.
- One sub-module, imem_array: MEM_WORDS x 32 storage with one async read port and one sync write port. It keeps the storage swappable for an SRAM macro.
- FSM, counter and buffer stay in imem_ctrl.

Test Plan:
- Reset, then load_en writes 0xDEADBEEF at 0x10 and 0x00500093 at 0x14; LATENCY=2, req addr 0x10 -> ready drops next cycle, valid=1 with data 0xDEADBEEF and err=0 exactly 2 cycles after accept, ready back one cycle later.
- Hold req high with addr 0x10 then 0x14 -> responses 0xDEADBEEF then 0x00500093, accepts spaced LATENCY+1=3 cycles apart, no extra valid pulses.
- Accept 0x10, assert flush in WAIT -> no valid pulse, ready=1 next cycle; req 0x14 in that same cycle is accepted and returns 0x00500093.
- req addr 0x00100000 with MEM_WORDS=1024 -> valid with data 0x00000013 and err=1; addr 0x13 (unaligned) returns the word at 0x10.
- Accept 0x10, then load_en writes 0x11111111 to 0x10 during WAIT -> response 0xDEADBEEF; the next fetch of 0x10 returns 0x11111111.
- Assert rst during WAIT -> valid never pulses, ready=1 the cycle after rst deasserts, memory contents intact; repeat with LATENCY=1 to check valid one cycle after accept.

Source files
------------

// File: rtl/imem_ctrl_pkg.sv
// Shared definitions for the instruction-memory controller: the NOP word
// used for out-of-range fetches and the controller state encoding.
`ifndef IMEM_NOP
`define IMEM_NOP 32'h00000013
`endif

package imem_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        WAIT = ST_WAIT,
        RESP = ST_RESP
    } imem_state_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one asynchronous read port, one synchronous write port.
// Kept separate so an SRAM macro can be dropped in without touching the FSM.
module imem_array #(
    parameter int WORDS = 1024,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_ctrl.sv
// Fetch-side responder: accepts one word-aligned fetch at a time and returns
// the instruction LATENCY cycles after acceptance, with flush and a load port.
module imem_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int          MEM_WORDS = 1024,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] NOP_INSN  = `IMEM_NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        proc2Imem_req,
    input  logic [31:0] proc2Imem_addr,
    input  logic        proc2Imem_flush,
    output logic        Imem2proc_ready,
    output logic        Imem2proc_valid,
    output logic [31:0] Imem2proc_data,
    output logic        Imem2proc_err,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [CNT_W-1:0] WAIT_INIT = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $fatal(1, "imem_ctrl: LATENCY must be within 1..15");
    end

    // Handshake: a fetch is accepted on any edge where req and ready are both
    // high; valid is a one-cycle pulse that needs no ready from the requester.
    imem_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      buf_data;
    logic             buf_err;
    logic [31:0]      last_data;
    logic [31:0]      rd_data;
    logic             accept;
    logic             fetch_oor;
    logic             load_oor;
    logic             unused_addr_bits;

    assign fetch_oor        = proc2Imem_addr[31:AW+2] != '0;
    assign load_oor         = load_addr[31:AW+2] != '0;
    assign unused_addr_bits = ^{proc2Imem_addr[1:0], load_addr[1:0]};

    imem_array #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (load_en && !load_oor),
        .waddr (load_addr[AW+1:2]),
        .wdata (load_data),
        .raddr (proc2Imem_addr[AW+1:2]),
        .rdata (rd_data)
    );

    assign Imem2proc_ready = (state == IDLE) && !rst;
    assign accept          = proc2Imem_req && Imem2proc_ready;

    // Flush and reset both kill a response in the very cycle it would appear.
    assign Imem2proc_valid = (state == RESP) && !proc2Imem_flush && !rst;
    assign Imem2proc_data  = Imem2proc_valid ? buf_data : last_data;
    assign Imem2proc_err   = Imem2proc_valid && buf_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            buf_data  <= '0;
            buf_err   <= 1'b0;
            last_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Read happens before a same-edge load lands, so the old word wins.
                        buf_data <= fetch_oor ? NOP_INSN : rd_data;
                        buf_err  <= fetch_oor;
                        cnt      <= WAIT_INIT;
                        state    <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (proc2Imem_flush) begin
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    if (!proc2Imem_flush) begin
                        last_data <= buf_data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_ctrl.sv
// Directed bench for imem_ctrl: two instances (LATENCY 2 and 1) share stimulus
// and are checked every cycle against a transaction-level timeline model.
module tb_imem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [31:0] addr = '0;
    logic        flush = 1'b0;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;

    logic        rdy1, vld1, err1;
    logic [31:0] dat1;
    logic        rdy2, vld2, err2;
    logic [31:0] dat2;

    always #5 clk = ~clk;

    imem_ctrl #(.MEM_WORDS(1024), .LATENCY(2), .NOP_INSN(32'h00000013)) dut1 (
        .clk             (clk),
        .rst             (rst),
        .proc2Imem_req   (req),
        .proc2Imem_addr  (addr),
        .proc2Imem_flush (flush),
        .Imem2proc_ready (rdy1),
        .Imem2proc_valid (vld1),
        .Imem2proc_data  (dat1),
        .Imem2proc_err   (err1),
        .load_en         (load_en),
        .load_addr       (load_addr),
        .load_data       (load_data)
    );

    imem_ctrl #(.MEM_WORDS(1024), .LATENCY(1), .NOP_INSN(32'h00000013)) dut2 (
        .clk             (clk),
        .rst             (rst),
        .proc2Imem_req   (req),
        .proc2Imem_addr  (addr),
        .proc2Imem_flush (flush),
        .Imem2proc_ready (rdy2),
        .Imem2proc_valid (vld2),
        .Imem2proc_data  (dat2),
        .Imem2proc_err   (err2),
        .load_en         (load_en),
        .load_addr       (load_addr),
        .load_data       (load_data)
    );

    int n_cmp = 0;
    int n_mis = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endfunction

    // ---------------- timeline model ----------------
    // A fetch accepted on edge A is visible (valid) in the cycle after edge
    // A+LAT-1 and the responder is busy until that response cycle ends.
    int          lat_m [2] = '{2, 1};
    logic [31:0] mem_m [int];
    int          now = 0;
    bit          chk_en = 1'b0;
    bit          m_pend [2] = '{1'b0, 1'b0};
    int          m_acc [2];
    logic [31:0] m_bdata [2];
    bit          m_berr [2];
    bit          m_bknown [2];
    logic [31:0] m_last [2];
    bit          m_lastknown [2] = '{1'b0, 1'b0};

    function automatic bit resp_due(int k);
        return m_pend[k] && (now - m_acc[k] == lat_m[k] - 1);
    endfunction

    always @(posedge clk) begin : model
        bit vr;
        for (int k = 0; k < 2; k++) begin
            vr = resp_due(k);
            if (rst) begin
                m_pend[k]      = 1'b0;
                m_last[k]      = '0;
                m_lastknown[k] = 1'b1;
            end else if (m_pend[k]) begin
                if (flush || vr) m_pend[k] = 1'b0;
                if (vr && !flush) begin
                    m_last[k]      = m_bdata[k];
                    m_lastknown[k] = m_bknown[k];
                end
            end else if (req) begin
                m_pend[k] = 1'b1;
                m_acc[k]  = now + 1;
                if (addr[31:12] != 0) begin
                    m_bdata[k]  = 32'h00000013;
                    m_berr[k]   = 1'b1;
                    m_bknown[k] = 1'b1;
                end else begin
                    m_berr[k]   = 1'b0;
                    m_bknown[k] = mem_m.exists(int'(addr[11:2]));
                    m_bdata[k]  = m_bknown[k] ? mem_m[int'(addr[11:2])] : 32'h0;
                end
            end
        end
        if (load_en && load_addr[31:12] == 0) mem_m[int'(load_addr[11:2])] = load_data;
        if (rst) chk_en = 1'b1;
        now++;
    end

    // ---------------- monitor + per-cycle compare ----------------
    bit          rdy1_h [4096];
    int          acc_q1[$], vcyc_q1[$], acc_q2[$], vcyc_q2[$];
    logic [31:0] got_q1[$], got_q2[$];
    bit          gerr_q1[$];

    always @(negedge clk) begin : compare
        logic        a_rdy, a_vld, a_err, e_rdy, e_vld, e_err, e_known;
        logic [31:0] a_dat, e_dat;
        string       tag;
        if (now < 4096) rdy1_h[now] = rdy1;
        if (req && rdy1) acc_q1.push_back(now);
        if (req && rdy2) acc_q2.push_back(now);
        if (vld1) begin
            vcyc_q1.push_back(now);
            got_q1.push_back(dat1);
            gerr_q1.push_back(err1);
        end
        if (vld2) begin
            vcyc_q2.push_back(now);
            got_q2.push_back(dat2);
        end
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                a_rdy   = (k == 0) ? rdy1 : rdy2;
                a_vld   = (k == 0) ? vld1 : vld2;
                a_err   = (k == 0) ? err1 : err2;
                a_dat   = (k == 0) ? dat1 : dat2;
                tag     = $sformatf("lat%0d_c%0d", lat_m[k], now);
                e_rdy   = !rst && !m_pend[k];
                e_vld   = resp_due(k) && !flush && !rst;
                e_err   = e_vld && m_berr[k];
                e_dat   = e_vld ? m_bdata[k] : m_last[k];
                e_known = e_vld ? m_bknown[k] : m_lastknown[k];
                chk({tag, "_ready"}, {31'b0, a_rdy}, {31'b0, e_rdy});
                chk({tag, "_valid"}, {31'b0, a_vld}, {31'b0, e_vld});
                chk({tag, "_err"}, {31'b0, a_err}, {31'b0, e_err});
                if (e_known) chk({tag, "_data"}, a_dat, e_dat);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic cycles(int n);
        repeat (n) step();
    endtask

    task automatic load(logic [31:0] a, logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_en   = 1'b0;
    endtask

    task automatic wait_rdy1();
        for (int i = 0; i < 20 && !rdy1; i++) step();
        chk("wait_ready", {31'b0, rdy1}, 32'd1);
    endtask

    task automatic fetch1(logic [31:0] a);
        wait_rdy1();
        req  = 1'b1;
        addr = a;
        step();
        req  = 1'b0;
    endtask

    task automatic clear_q();
        acc_q1.delete(); vcyc_q1.delete(); got_q1.delete(); gerr_q1.delete();
        acc_q2.delete(); vcyc_q2.delete(); got_q2.delete();
    endtask

    initial begin
        cycles(3);
        rst = 1'b0;
        #1;
        chk("rst_ready", {31'b0, rdy1}, 32'd1);
        chk("rst_valid", {31'b0, vld1}, 32'd0);
        chk("rst_data", dat1, 32'h0);
        chk("rst_err", {31'b0, err1}, 32'd0);
        chk("rst_ready_l1", {31'b0, rdy2}, 32'd1);

        // Basic fetch with LATENCY 2 (and 1 on the second instance).
        load(32'h10, 32'hDEADBEEF);
        load(32'h14, 32'h00500093);
        clear_q();
        fetch1(32'h10);
        #1;
        chk("t1_ready_drop", {31'b0, rdy1}, 32'd0);
        cycles(6);
        chk("t1_nresp", got_q1.size(), 1);
        if (got_q1.size() == 1 && acc_q1.size() == 1) begin
            chk("t1_data", got_q1[0], 32'hDEADBEEF);
            chk("t1_err", {31'b0, gerr_q1[0]}, 32'd0);
            chk("t1_latency", vcyc_q1[0] - acc_q1[0], 32'd2);
            chk("t1_ready_back", {31'b0, rdy1_h[vcyc_q1[0] + 1]}, 32'd1);
        end
        chk("t1_l1_nresp", got_q2.size(), 1);
        if (vcyc_q2.size() == 1 && acc_q2.size() == 1)
            chk("t1_l1_latency", vcyc_q2[0] - acc_q2[0], 32'd1);

        // Held request: throughput of one fetch per LATENCY+1 cycles.
        clear_q();
        req  = 1'b1;
        addr = 32'h10;
        for (int i = 0; i < 20 && acc_q1.size() < 1; i++) step();
        addr = 32'h14;
        for (int i = 0; i < 20 && acc_q1.size() < 2; i++) step();
        req = 1'b0;
        cycles(6);
        chk("t2_nacc", acc_q1.size(), 2);
        chk("t2_nresp", got_q1.size(), 2);
        if (got_q1.size() == 2 && acc_q1.size() == 2) begin
            chk("t2_data0", got_q1[0], 32'hDEADBEEF);
            chk("t2_data1", got_q1[1], 32'h00500093);
            chk("t2_spacing", acc_q1[1] - acc_q1[0], 32'd3);
        end

        // Flush while waiting, then immediate re-request.
        clear_q();
        fetch1(32'h10);
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        chk("t3_ready_after_flush", {31'b0, rdy1}, 32'd1);
        req  = 1'b1;
        addr = 32'h14;
        step();
        req = 1'b0;
        cycles(6);
        chk("t3_nresp", got_q1.size(), 1);
        if (got_q1.size() == 1) chk("t3_data", got_q1[0], 32'h00500093);
        chk("t3_l1_nresp", got_q2.size(), 1);
        if (got_q2.size() == 1) chk("t3_l1_data", got_q2[0], 32'h00500093);

        // Out-of-range and unaligned addresses.
        clear_q();
        fetch1(32'h00100000);
        cycles(4);
        fetch1(32'h13);
        cycles(4);
        chk("t4_nresp", got_q1.size(), 2);
        if (got_q1.size() == 2) begin
            chk("t4_oor_data", got_q1[0], 32'h00000013);
            chk("t4_oor_err", {31'b0, gerr_q1[0]}, 32'd1);
            chk("t4_unaligned_data", got_q1[1], 32'hDEADBEEF);
            chk("t4_unaligned_err", {31'b0, gerr_q1[1]}, 32'd0);
        end
        chk("t4_hold_data", dat1, 32'hDEADBEEF);
        chk("t4_idle_err", {31'b0, err1}, 32'd0);

        // Loads racing fetches, and a dropped out-of-range load.
        clear_q();
        fetch1(32'h10);
        load(32'h10, 32'h11111111);
        cycles(4);
        fetch1(32'h10);
        cycles(4);
        wait_rdy1();
        req       = 1'b1;
        addr      = 32'h14;
        load_en   = 1'b1;
        load_addr = 32'h14;
        load_data = 32'h22222222;
        step();
        req     = 1'b0;
        load_en = 1'b0;
        cycles(4);
        fetch1(32'h14);
        cycles(4);
        load(32'h00100010, 32'hBADBAD00);
        fetch1(32'h10);
        cycles(4);
        chk("t5_nresp", got_q1.size(), 5);
        if (got_q1.size() == 5) begin
            chk("t5_pending_kept", got_q1[0], 32'hDEADBEEF);
            chk("t5_load_seen", got_q1[1], 32'h11111111);
            chk("t5_same_cycle_old", got_q1[2], 32'h00500093);
            chk("t5_same_cycle_new", got_q1[3], 32'h22222222);
            chk("t5_oor_load_dropped", got_q1[4], 32'h11111111);
        end

        // Reset in the middle of a fetch.
        clear_q();
        fetch1(32'h10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("t6_ready_after_rst", {31'b0, rdy1}, 32'd1);
        chk("t6_data_cleared", dat1, 32'h0);
        cycles(6);
        chk("t6_no_resp", got_q1.size(), 0);
        chk("t6_l1_no_resp", got_q2.size(), 0);
        clear_q();
        fetch1(32'h10);
        cycles(4);
        chk("t6_nresp", got_q1.size(), 1);
        if (got_q1.size() == 1) chk("t6_mem_intact", got_q1[0], 32'h11111111);
        chk("t6_l1_nresp", got_q2.size(), 1);
        if (got_q2.size() == 1 && acc_q2.size() == 1) begin
            chk("t6_l1_data", got_q2[0], 32'h11111111);
            chk("t6_l1_latency", vcyc_q2[0] - acc_q2[0], 32'd1);
        end

        cycles(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
